// File: rtl/hazard_unit_pkg.sv
// Shared types and constants for the pipeline hazard unit: controller states,
// ALU operand forward selects, and the hard-wired zero register.
package hazard_unit_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    STALL = 2'd1,
    FLUSH = 2'd2
  } state_t;

  localparam logic [1:0] FWD_REG   = 2'b00;
  localparam logic [1:0] FWD_EXMEM = 2'b10;
  localparam logic [1:0] FWD_MEMWB = 2'b01;

  localparam logic [4:0] REG_ZERO = 5'd0;

  // A later stage produces a register the ID instruction reads; $0 never counts.
  function automatic logic src_match(
    input logic       we,
    input logic [4:0] dst,
    input logic [4:0] rs,
    input logic [4:0] rt,
    input logic       uses_rt
  );
    return we && (dst != REG_ZERO) && ((dst == rs) || (uses_rt && (dst == rt)));
  endfunction

endpackage

// File: rtl/hazard_unit_fwd_sel.sv
// Per-operand ALU forward selector; built only with HAZARD_UNIT_FWD_EN defined.
// The younger EX/MEM result wins over MEM/WB; $0 is never forwarded.
`ifdef HAZARD_UNIT_FWD_EN
module hazard_fwd_sel
  import hazard_unit_pkg::*;
(
  input  logic [4:0] src,
  input  logic       exmem_we,
  input  logic [4:0] exmem_dst,
  input  logic       memwb_we,
  input  logic [4:0] memwb_dst,
  output logic [1:0] sel
);

  always_comb begin
    sel = FWD_REG;
    if (src != REG_ZERO) begin
      if (exmem_we && (exmem_dst == src)) begin
        sel = FWD_EXMEM;
      end else if (memwb_we && (memwb_dst == src)) begin
        sel = FWD_MEMWB;
      end
    end
  end

endmodule
`endif

// File: rtl/hazard_unit.sv
// Pipeline hazard unit: stall/flush controller with a saturating stall counter.
// Define HAZARD_UNIT_FWD_EN for the forwarding build (load-use stalls only).
module hazard_unit
  import hazard_unit_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  ifidRsIN,
  input  logic [4:0]  ifidRtIN,
  input  logic        ifidUsesRtIN,
  input  logic        idexMemReadIN,
  input  logic        idexRegWriteIN,
  input  logic [4:0]  idexDstIN,
  input  logic        exmemRegWriteIN,
  input  logic [4:0]  exmemDstIN,
  input  logic        memwbRegWriteIN,
  input  logic [4:0]  memwbDstIN,
  input  logic [4:0]  idexRsIN,
  input  logic [4:0]  idexRtIN,
  input  logic        branchTakenIN,
  output logic        pcWriteOUT,
  output logic        ifidWriteOUT,
  output logic        idexBubbleOUT,
  output logic        ifidFlushOUT,
  output logic        idexFlushOUT,
  output logic        exmemFlushOUT,
  output logic [1:0]  fwdAOUT,
  output logic [1:0]  fwdBOUT,
  output logic [15:0] stallCountOUT
);

  state_t     state, state_nxt;
  logic [1:0] cnt, cnt_nxt;
  logic [1:0] need;
  logic       ex_match;
  logic [1:0] fwd_a, fwd_b;

  assign ex_match = src_match(idexRegWriteIN, idexDstIN, ifidRsIN, ifidRtIN, ifidUsesRtIN);

`ifdef HAZARD_UNIT_FWD_EN
  // Only a load still in EX cannot be forwarded in time.
  assign need = (idexMemReadIN && ex_match) ? 2'd1 : 2'd0;

  hazard_fwd_sel u_fwd_a (
    .src       (idexRsIN),
    .exmem_we  (exmemRegWriteIN),
    .exmem_dst (exmemDstIN),
    .memwb_we  (memwbRegWriteIN),
    .memwb_dst (memwbDstIN),
    .sel       (fwd_a)
  );

  hazard_fwd_sel u_fwd_b (
    .src       (idexRtIN),
    .exmem_we  (exmemRegWriteIN),
    .exmem_dst (exmemDstIN),
    .memwb_we  (memwbRegWriteIN),
    .memwb_dst (memwbDstIN),
    .sel       (fwd_b)
  );
`else
  logic mem_match;
  logic unused_fwd_inputs;

  assign mem_match = src_match(exmemRegWriteIN, exmemDstIN, ifidRsIN, ifidRtIN, ifidUsesRtIN);
  // WB producers need no stall: the register file writes before it is read.
  assign need  = ex_match ? 2'd2 : (mem_match ? 2'd1 : 2'd0);
  assign fwd_a = FWD_REG;
  assign fwd_b = FWD_REG;
  assign unused_fwd_inputs = ^{idexRsIN, idexRtIN, memwbRegWriteIN, memwbDstIN, idexMemReadIN};
`endif

  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt;
    pcWriteOUT    = 1'b1;
    ifidWriteOUT  = 1'b1;
    idexBubbleOUT = 1'b0;
    ifidFlushOUT  = 1'b0;
    idexFlushOUT  = 1'b0;
    exmemFlushOUT = 1'b0;
    fwdAOUT       = fwd_a;
    fwdBOUT       = fwd_b;
    if (!rst_n) begin
      pcWriteOUT    = 1'b0;
      ifidWriteOUT  = 1'b0;
      idexBubbleOUT = 1'b1;
      ifidFlushOUT  = 1'b1;
      idexFlushOUT  = 1'b1;
      exmemFlushOUT = 1'b1;
      fwdAOUT       = FWD_REG;
      fwdBOUT       = FWD_REG;
    end else if (branchTakenIN) begin
      ifidFlushOUT  = 1'b1;
      idexFlushOUT  = 1'b1;
      exmemFlushOUT = 1'b1;
      cnt_nxt       = 2'd0;
      state_nxt     = FLUSH;
    end else begin
      unique case (state)
        RUN: begin
          if (need != 2'd0) begin
            pcWriteOUT    = 1'b0;
            ifidWriteOUT  = 1'b0;
            idexBubbleOUT = 1'b1;
            cnt_nxt       = need - 2'd1;
            state_nxt     = (need == 2'd1) ? RUN : STALL;
          end
        end
        STALL: begin
          // cnt counts the stall cycles still owed, this one included.
          pcWriteOUT    = 1'b0;
          ifidWriteOUT  = 1'b0;
          idexBubbleOUT = 1'b1;
          if (cnt <= 2'd1) begin
            cnt_nxt   = 2'd0;
            state_nxt = RUN;
          end else begin
            cnt_nxt = cnt - 2'd1;
          end
        end
        FLUSH: begin
          state_nxt = RUN;
        end
        default: begin
          cnt_nxt   = 2'd0;
          state_nxt = RUN;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= RUN;
      cnt           <= 2'd0;
      stallCountOUT <= 16'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (idexBubbleOUT && (stallCountOUT != 16'hFFFF)) begin
        stallCountOUT <= stallCountOUT + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_hazard_unit.sv
// Directed bench for hazard_unit; covers both builds via HAZARD_UNIT_FWD_EN.
module tb_hazard_unit;

  logic        clk;
  logic        rst_n;
  logic [4:0]  ifidRsIN, ifidRtIN;
  logic        ifidUsesRtIN;
  logic        idexMemReadIN, idexRegWriteIN;
  logic [4:0]  idexDstIN;
  logic        exmemRegWriteIN;
  logic [4:0]  exmemDstIN;
  logic        memwbRegWriteIN;
  logic [4:0]  memwbDstIN;
  logic [4:0]  idexRsIN, idexRtIN;
  logic        branchTakenIN;
  logic        pcWriteOUT, ifidWriteOUT, idexBubbleOUT;
  logic        ifidFlushOUT, idexFlushOUT, exmemFlushOUT;
  logic [1:0]  fwdAOUT, fwdBOUT;
  logic [15:0] stallCountOUT;

  int pass_cnt = 0;
  int total_cnt = 0;

  hazard_unit dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .ifidRsIN        (ifidRsIN),
    .ifidRtIN        (ifidRtIN),
    .ifidUsesRtIN    (ifidUsesRtIN),
    .idexMemReadIN   (idexMemReadIN),
    .idexRegWriteIN  (idexRegWriteIN),
    .idexDstIN       (idexDstIN),
    .exmemRegWriteIN (exmemRegWriteIN),
    .exmemDstIN      (exmemDstIN),
    .memwbRegWriteIN (memwbRegWriteIN),
    .memwbDstIN      (memwbDstIN),
    .idexRsIN        (idexRsIN),
    .idexRtIN        (idexRtIN),
    .branchTakenIN   (branchTakenIN),
    .pcWriteOUT      (pcWriteOUT),
    .ifidWriteOUT    (ifidWriteOUT),
    .idexBubbleOUT   (idexBubbleOUT),
    .ifidFlushOUT    (ifidFlushOUT),
    .idexFlushOUT    (idexFlushOUT),
    .exmemFlushOUT   (exmemFlushOUT),
    .fwdAOUT         (fwdAOUT),
    .fwdBOUT         (fwdBOUT),
    .stallCountOUT   (stallCountOUT)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    ifidRsIN = 5'd0; ifidRtIN = 5'd0; ifidUsesRtIN = 1'b0;
    idexMemReadIN = 1'b0; idexRegWriteIN = 1'b0; idexDstIN = 5'd0;
    exmemRegWriteIN = 1'b0; exmemDstIN = 5'd0;
    memwbRegWriteIN = 1'b0; memwbDstIN = 5'd0;
    idexRsIN = 5'd0; idexRtIN = 5'd0; branchTakenIN = 1'b0;
  endtask

  // Load r8 in EX while ID reads rs=r8.
  task automatic set_load_use();
    idexMemReadIN = 1'b1; idexRegWriteIN = 1'b1; idexDstIN = 5'd8; ifidRsIN = 5'd8;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    clear_inputs();
    exmemRegWriteIN = 1'b1; exmemDstIN = 5'd4; idexRsIN = 5'd4; idexRtIN = 5'd4;
    #1;
    total_cnt++; if (pcWriteOUT !== 1'b0) $display("FAIL rst_pc got %b want 0", pcWriteOUT); else pass_cnt++;
    total_cnt++; if (ifidWriteOUT !== 1'b0) $display("FAIL rst_ifid_we got %b want 0", ifidWriteOUT); else pass_cnt++;
    total_cnt++; if (idexBubbleOUT !== 1'b1) $display("FAIL rst_bubble got %b want 1", idexBubbleOUT); else pass_cnt++;
    total_cnt++;
    if ({ifidFlushOUT, idexFlushOUT, exmemFlushOUT} !== 3'b111)
      $display("FAIL rst_flush got %b want 111", {ifidFlushOUT, idexFlushOUT, exmemFlushOUT});
    else pass_cnt++;
    total_cnt++;
    if ({fwdAOUT, fwdBOUT} !== 4'b0000) $display("FAIL rst_fwd got %b want 0000", {fwdAOUT, fwdBOUT}); else pass_cnt++;
    step();
    step();
    total_cnt++; if (stallCountOUT !== 16'd0) $display("FAIL rst_count got %0d want 0", stallCountOUT); else pass_cnt++;
  endtask

  task automatic test_idle_and_r0();
    rst_n = 1'b1;
    clear_inputs();
    #1;
    total_cnt++; if (pcWriteOUT !== 1'b1) $display("FAIL idle_pc got %b want 1", pcWriteOUT); else pass_cnt++;
    total_cnt++; if (ifidWriteOUT !== 1'b1) $display("FAIL idle_ifid_we got %b want 1", ifidWriteOUT); else pass_cnt++;
    total_cnt++; if (idexBubbleOUT !== 1'b0) $display("FAIL idle_bubble got %b want 0", idexBubbleOUT); else pass_cnt++;
    total_cnt++;
    if ({ifidFlushOUT, idexFlushOUT, exmemFlushOUT} !== 3'b000)
      $display("FAIL idle_flush got %b want 000", {ifidFlushOUT, idexFlushOUT, exmemFlushOUT});
    else pass_cnt++;
    step();
    // $0 producers in every stage must never stall.
    idexMemReadIN = 1'b1; idexRegWriteIN = 1'b1; idexDstIN = 5'd0;
    exmemRegWriteIN = 1'b1; exmemDstIN = 5'd0;
    ifidRsIN = 5'd0; ifidRtIN = 5'd0; ifidUsesRtIN = 1'b1;
    #1;
    total_cnt++; if (pcWriteOUT !== 1'b1) $display("FAIL r0_pc got %b want 1", pcWriteOUT); else pass_cnt++;
    total_cnt++; if (idexBubbleOUT !== 1'b0) $display("FAIL r0_bubble got %b want 0", idexBubbleOUT); else pass_cnt++;
    step();
    clear_inputs();
  endtask

`ifdef HAZARD_UNIT_FWD_EN
  task automatic test_build_specific();
    set_load_use();
    #1;
    total_cnt++; if (pcWriteOUT !== 1'b0) $display("FAIL ld_stall_pc got %b want 0", pcWriteOUT); else pass_cnt++;
    total_cnt++; if (idexBubbleOUT !== 1'b1) $display("FAIL ld_stall_bubble got %b want 1", idexBubbleOUT); else pass_cnt++;
    step();
    // Load advances to MEM, consumer is now in EX.
    clear_inputs();
    exmemRegWriteIN = 1'b1; exmemDstIN = 5'd8; idexRsIN = 5'd8; ifidRsIN = 5'd8;
    #1;
    total_cnt++; if (pcWriteOUT !== 1'b1) $display("FAIL ld_release_pc got %b want 1", pcWriteOUT); else pass_cnt++;
    total_cnt++; if (stallCountOUT !== 16'd1) $display("FAIL ld_count got %0d want 1", stallCountOUT); else pass_cnt++;
    total_cnt++; if (fwdAOUT !== 2'b10) $display("FAIL ld_fwd_a got %b want 10", fwdAOUT); else pass_cnt++;
    step();
    clear_inputs();
    idexRegWriteIN = 1'b1; idexDstIN = 5'd8; ifidRsIN = 5'd8;
    #1;
    total_cnt++; if (pcWriteOUT !== 1'b1) $display("FAIL alu_nostall_pc got %b want 1", pcWriteOUT); else pass_cnt++;
    step();
    clear_inputs();
    exmemRegWriteIN = 1'b1; exmemDstIN = 5'd3; memwbRegWriteIN = 1'b1; memwbDstIN = 5'd3;
    idexRsIN = 5'd3; idexRtIN = 5'd0;
    #1;
    total_cnt++; if (fwdAOUT !== 2'b10) $display("FAIL fwd_prio_a got %b want 10", fwdAOUT); else pass_cnt++;
    total_cnt++; if (fwdBOUT !== 2'b00) $display("FAIL fwd_b_other got %b want 00", fwdBOUT); else pass_cnt++;
    exmemDstIN = 5'd0; memwbDstIN = 5'd0;
    #1;
    total_cnt++; if (fwdBOUT !== 2'b00) $display("FAIL fwd_r0_b got %b want 00", fwdBOUT); else pass_cnt++;
    exmemDstIN = 5'd5; memwbDstIN = 5'd3; idexRtIN = 5'd3;
    #1;
    total_cnt++; if (fwdBOUT !== 2'b01) $display("FAIL fwd_memwb_b got %b want 01", fwdBOUT); else pass_cnt++;
    total_cnt++; if (stallCountOUT !== 16'd1) $display("FAIL fwd_count got %0d want 1", stallCountOUT); else pass_cnt++;
    step();
    clear_inputs();
  endtask
`else
  task automatic test_build_specific();
    idexRegWriteIN = 1'b1; idexDstIN = 5'd9; ifidRsIN = 5'd1; ifidRtIN = 5'd9; ifidUsesRtIN = 1'b1;
    exmemRegWriteIN = 1'b1; exmemDstIN = 5'd1; idexRsIN = 5'd1;
    #1;
    total_cnt++; if (pcWriteOUT !== 1'b0) $display("FAIL ex_stall1_pc got %b want 0", pcWriteOUT); else pass_cnt++;
    total_cnt++; if (ifidWriteOUT !== 1'b0) $display("FAIL ex_stall1_ifid got %b want 0", ifidWriteOUT); else pass_cnt++;
    total_cnt++; if ({fwdAOUT, fwdBOUT} !== 4'b0000) $display("FAIL nofwd_tied got %b want 0000", {fwdAOUT, fwdBOUT}); else pass_cnt++;
    step();
    // Producer moves to MEM; a bubble now sits in EX.
    clear_inputs();
    exmemRegWriteIN = 1'b1; exmemDstIN = 5'd9; ifidRsIN = 5'd1; ifidRtIN = 5'd9; ifidUsesRtIN = 1'b1;
    #1;
    total_cnt++; if (idexBubbleOUT !== 1'b1) $display("FAIL ex_stall2_bubble got %b want 1", idexBubbleOUT); else pass_cnt++;
    step();
    clear_inputs();
    memwbRegWriteIN = 1'b1; memwbDstIN = 5'd9; ifidRsIN = 5'd1; ifidRtIN = 5'd9; ifidUsesRtIN = 1'b1;
    #1;
    total_cnt++; if (pcWriteOUT !== 1'b1) $display("FAIL ex_run_pc got %b want 1", pcWriteOUT); else pass_cnt++;
    total_cnt++; if (stallCountOUT !== 16'd2) $display("FAIL ex_count got %0d want 2", stallCountOUT); else pass_cnt++;
    step();
    clear_inputs();
    idexRegWriteIN = 1'b1; idexDstIN = 5'd9; ifidRsIN = 5'd1; ifidRtIN = 5'd9; ifidUsesRtIN = 1'b0;
    #1;
    total_cnt++; if (pcWriteOUT !== 1'b1) $display("FAIL no_rt_pc got %b want 1", pcWriteOUT); else pass_cnt++;
    step();
    clear_inputs();
    exmemRegWriteIN = 1'b1; exmemDstIN = 5'd6; ifidRsIN = 5'd6;
    #1;
    total_cnt++; if (pcWriteOUT !== 1'b0) $display("FAIL mem_stall_pc got %b want 0", pcWriteOUT); else pass_cnt++;
    step();
    clear_inputs();
    memwbRegWriteIN = 1'b1; memwbDstIN = 5'd6; ifidRsIN = 5'd6;
    #1;
    total_cnt++; if (pcWriteOUT !== 1'b1) $display("FAIL mem_run_pc got %b want 1", pcWriteOUT); else pass_cnt++;
    total_cnt++; if (stallCountOUT !== 16'd3) $display("FAIL mem_count got %0d want 3", stallCountOUT); else pass_cnt++;
    step();
    clear_inputs();
  endtask
`endif

  task automatic test_branch_in_stall();
    set_load_use();
    #1;
    total_cnt++; if (pcWriteOUT !== 1'b0) $display("FAIL br_stall1_pc got %b want 0", pcWriteOUT); else pass_cnt++;
    step();
    branchTakenIN = 1'b1;
    #1;
    total_cnt++;
    if ({ifidFlushOUT, idexFlushOUT, exmemFlushOUT} !== 3'b111)
      $display("FAIL br_flush got %b want 111", {ifidFlushOUT, idexFlushOUT, exmemFlushOUT});
    else pass_cnt++;
    total_cnt++; if (pcWriteOUT !== 1'b1) $display("FAIL br_pc got %b want 1", pcWriteOUT); else pass_cnt++;
    total_cnt++; if (idexBubbleOUT !== 1'b0) $display("FAIL br_bubble got %b want 0", idexBubbleOUT); else pass_cnt++;
    step();
    branchTakenIN = 1'b0;
    #1;
    total_cnt++; if (pcWriteOUT !== 1'b1) $display("FAIL flush_state_pc got %b want 1", pcWriteOUT); else pass_cnt++;
    total_cnt++;
    if ({ifidFlushOUT, idexFlushOUT, exmemFlushOUT} !== 3'b000)
      $display("FAIL flush_state_flush got %b want 000", {ifidFlushOUT, idexFlushOUT, exmemFlushOUT});
    else pass_cnt++;
    step();
    #1;
    total_cnt++; if (pcWriteOUT !== 1'b0) $display("FAIL after_flush_run_pc got %b want 0", pcWriteOUT); else pass_cnt++;
    clear_inputs();
    step(); step(); step();
  endtask

  task automatic test_saturation();
    set_load_use();
    for (int i = 0; i < 70000; i++) step();
    total_cnt++; if (stallCountOUT !== 16'hFFFF) $display("FAIL sat_count got %h want ffff", stallCountOUT); else pass_cnt++;
    step();
    total_cnt++; if (stallCountOUT !== 16'hFFFF) $display("FAIL sat_hold got %h want ffff", stallCountOUT); else pass_cnt++;
    clear_inputs();
    step(); step(); step();
  endtask

  task automatic test_reset_mid_stall();
    set_load_use();
    step();
    // Now mid-stall; pulse reset with a forwardable producer visible.
    rst_n = 1'b0;
    exmemRegWriteIN = 1'b1; exmemDstIN = 5'd8; idexRsIN = 5'd8;
    #1;
    total_cnt++; if (pcWriteOUT !== 1'b0) $display("FAIL mid_rst_pc got %b want 0", pcWriteOUT); else pass_cnt++;
    total_cnt++; if (idexBubbleOUT !== 1'b1) $display("FAIL mid_rst_bubble got %b want 1", idexBubbleOUT); else pass_cnt++;
    total_cnt++; if (fwdAOUT !== 2'b00) $display("FAIL mid_rst_fwd got %b want 00", fwdAOUT); else pass_cnt++;
    step();
    total_cnt++; if (stallCountOUT !== 16'd0) $display("FAIL mid_rst_count got %0d want 0", stallCountOUT); else pass_cnt++;
    rst_n = 1'b1;
    clear_inputs();
    #1;
    total_cnt++; if (pcWriteOUT !== 1'b1) $display("FAIL post_rst_pc got %b want 1", pcWriteOUT); else pass_cnt++;
    total_cnt++; if (idexBubbleOUT !== 1'b0) $display("FAIL post_rst_bubble got %b want 0", idexBubbleOUT); else pass_cnt++;
    step();
    total_cnt++; if (stallCountOUT !== 16'd0) $display("FAIL post_rst_count got %0d want 0", stallCountOUT); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_idle_and_r0();
    test_build_specific();
    test_branch_in_stall();
    test_saturation();
    test_reset_mid_stall();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
